// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_unit
// Purpose  : Fetch-stage program counter with prioritised next-PC selection
//            (exception, stall, jr, jump, branch, sequential), EPC capture,
//            redirect flush pulse and jr misalignment flag.
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h80000180),
  parameter int unsigned      INCR         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [15:0]      branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exception,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic             flush,
  output logic             addr_err
);

  localparam logic [2:0] c_sel_seq    = 3'd0;
  localparam logic [2:0] c_sel_stall  = 3'd1;
  localparam logic [2:0] c_sel_jr     = 3'd2;
  localparam logic [2:0] c_sel_jump   = 3'd3;
  localparam logic [2:0] c_sel_branch = 3'd4;
  localparam logic [2:0] c_sel_exc    = 3'd5;

  localparam logic [WIDTH-1:0] c_incr = WIDTH'(INCR);

  // The PC is kept as a word address so bits [1:0] are structurally zero.
  logic [WIDTH-1:2] r_pc_word;
  logic [WIDTH-1:0] r_epc;
  logic             r_flush;
  logic             r_addr_err;

  logic [2:0]       w_sel;
  logic [WIDTH-1:0] w_pc;
  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:2] w_br_disp;
  logic [WIDTH-1:2] w_br_word;
  logic [WIDTH-1:2] w_jump_word;
  logic [WIDTH-1:2] w_jr_word;
  logic [WIDTH-1:2] w_next_word;
  logic             w_redirect;
  logic             w_misaligned;

  assign w_pc       = {r_pc_word, 2'b00};
  assign w_pc_plus4 = w_pc + c_incr;

  always_comb begin
    w_sel = c_sel_seq;
    if (exception) begin
      w_sel = c_sel_exc;
    end else if (stall) begin
      w_sel = c_sel_stall;
    end else if (jr) begin
      w_sel = c_sel_jr;
    end else if (jump) begin
      w_sel = c_sel_jump;
    end else if (branch_taken) begin
      w_sel = c_sel_branch;
    end
  end

  // Branch displacement in words: sign-extended imm16, the <<2 is implicit.
  assign w_br_disp   = {{(WIDTH-18){branch_offset[15]}}, branch_offset};
  assign w_br_word   = w_pc_plus4[WIDTH-1:2] + w_br_disp;
  assign w_jump_word = {w_pc_plus4[WIDTH-1:28], jump_index};
  assign w_jr_word   = jr_target[WIDTH-1:2];

  always_comb begin
    w_next_word = w_pc_plus4[WIDTH-1:2];
    case (w_sel)
      c_sel_exc:    w_next_word = EXC_VECTOR[WIDTH-1:2];
      c_sel_stall:  w_next_word = r_pc_word;
      c_sel_jr:     w_next_word = w_jr_word;
      c_sel_jump:   w_next_word = w_jump_word;
      c_sel_branch: w_next_word = w_br_word;
      default:      w_next_word = w_pc_plus4[WIDTH-1:2];
    endcase
  end

  assign w_redirect   = (w_sel == c_sel_exc) || (w_sel == c_sel_jr) ||
                        (w_sel == c_sel_jump) || (w_sel == c_sel_branch);
  assign w_misaligned = (w_sel == c_sel_jr) && (jr_target[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_word  <= RESET_VECTOR[WIDTH-1:2];
      r_epc      <= '0;
      r_flush    <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_pc_word  <= w_next_word;
      r_flush    <= w_redirect;
      r_addr_err <= w_misaligned;
      if (w_sel == c_sel_exc) begin
        r_epc <= w_pc;
      end
    end
  end

  assign pc       = w_pc;
  assign pc_plus4 = w_pc_plus4;
  assign epc      = r_epc;
  assign flush    = r_flush;
  assign addr_err = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_next_unit
// Purpose  : Self-checking bench: directed vector table, reset sequence and
//            randomized run against a next-PC reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_next_unit;

  localparam logic [31:0] c_exc = 32'h80000180;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = '0;
  logic        exception = 1'b0;
  logic [31:0] pc, pc_plus4, epc;
  logic        flush, addr_err;

  int n_cmp = 0;
  int n_fail = 0;

  pc_next_unit #(
    .WIDTH(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(c_exc), .INCR(4)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
    .jr(jr), .jr_target(jr_target), .exception(exception),
    .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .flush(flush), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, br;
    logic [15:0] off;
    logic        jmp;
    logic [25:0] idx;
    logic        jrr;
    logic [31:0] tgt;
    logic        exc;
    logic [31:0] e_pc, e_epc;
    logic        e_fl, e_ae;
  } vec_t;

  function automatic vec_t mk(logic st, logic br, logic [15:0] off, logic jmp,
                              logic [25:0] idx, logic jrr, logic [31:0] tgt, logic exc,
                              logic [31:0] e_pc, logic [31:0] e_epc, logic e_fl, logic e_ae);
    vec_t v;
    v.st = st; v.br = br; v.off = off; v.jmp = jmp; v.idx = idx; v.jrr = jrr;
    v.tgt = tgt; v.exc = exc; v.e_pc = e_pc; v.e_epc = e_epc; v.e_fl = e_fl; v.e_ae = e_ae;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_epc,
                           input logic e_fl, input logic e_ae);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".pc_plus4"}, pc_plus4, e_pc + 32'd4);
    chk({tag, ".epc"}, epc, e_epc);
    chk({tag, ".flush"}, {31'b0, flush}, {31'b0, e_fl});
    chk({tag, ".addr_err"}, {31'b0, addr_err}, {31'b0, e_ae});
  endtask

  task automatic step(input logic st, input logic br, input logic [15:0] off, input logic jmp,
                      input logic [25:0] idx, input logic jrr, input logic [31:0] tgt,
                      input logic exc);
    stall = st; branch_taken = br; branch_offset = off; jump = jmp;
    jump_index = idx; jr = jrr; jr_target = tgt; exception = exc;
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  logic [31:0] m_pc, m_epc;
  logic        m_fl, m_ae;

  task automatic model_step(input logic st, input logic br, input logic [15:0] off,
                            input logic jmp, input logic [25:0] idx, input logic jrr,
                            input logic [31:0] tgt, input logic exc);
    logic [31:0] seq;
    int signed   disp;
    seq = m_pc + 32'd4;
    m_ae = 1'b0;
    if (exc) begin
      m_epc = m_pc; m_pc = c_exc; m_fl = 1'b1;
    end else if (st) begin
      m_fl = 1'b0;
    end else if (jrr) begin
      m_pc = tgt & 32'hFFFF_FFFC; m_fl = 1'b1; m_ae = (tgt % 4) != 0;
    end else if (jmp) begin
      m_pc = (seq & 32'hF000_0000) | (32'(idx) * 4); m_fl = 1'b1;
    end else if (br) begin
      disp = int'($signed(off)) * 4;
      m_pc = seq + 32'(disp); m_fl = 1'b1;
    end else begin
      m_pc = seq; m_fl = 1'b0;
    end
  endtask

  vec_t tbl[19];

  initial begin
    tbl[0]  = mk(0,0,16'h0,   0,26'h0,      0,32'h0,        0, 32'h4,        32'h0,  0,0);
    tbl[1]  = mk(0,0,16'h0,   0,26'h0,      1,32'h100,      0, 32'h100,      32'h0,  1,0);
    tbl[2]  = mk(0,1,16'hFFFF,0,26'h0,      0,32'h0,        0, 32'h100,      32'h0,  1,0);
    tbl[3]  = mk(0,0,16'h0,   0,26'h0,      0,32'h0,        0, 32'h104,      32'h0,  0,0);
    tbl[4]  = mk(0,1,16'h0003,0,26'h0,      0,32'h0,        0, 32'h114,      32'h0,  1,0);
    tbl[5]  = mk(0,0,16'h0,   0,26'h0,      1,32'h10000000, 0, 32'h10000000, 32'h0,  1,0);
    tbl[6]  = mk(0,0,16'h0,   1,26'h10,     0,32'h0,        0, 32'h10000040, 32'h0,  1,0);
    tbl[7]  = mk(0,0,16'h0,   0,26'h0,      1,32'h203,      0, 32'h200,      32'h0,  1,1);
    tbl[8]  = mk(0,0,16'h0,   0,26'h0,      1,32'h20,       0, 32'h20,       32'h0,  1,0);
    tbl[9]  = mk(1,0,16'h0,   1,26'h3FFFFFF,0,32'h0,        0, 32'h20,       32'h0,  0,0);
    tbl[10] = mk(1,0,16'h0,   0,26'h0,      0,32'h0,        1, c_exc,        32'h20, 1,0);
    tbl[11] = mk(0,0,16'h0,   0,26'h0,      1,32'h60,       0, 32'h60,       32'h20, 1,0);
    tbl[12] = mk(0,1,16'h0010,0,26'h0,      1,32'h61,       1, c_exc,        32'h60, 1,0);
    tbl[13] = mk(0,0,16'h0,   0,26'h0,      1,32'hFFFFFFFC, 0, 32'hFFFFFFFC, 32'h60, 1,0);
    tbl[14] = mk(0,0,16'h0,   0,26'h0,      0,32'h0,        0, 32'h0,        32'h60, 0,0);
    tbl[15] = mk(0,0,16'h0,   0,26'h0,      1,32'hFFFFFFF0, 0, 32'hFFFFFFF0, 32'h60, 1,0);
    tbl[16] = mk(0,1,16'h0004,0,26'h0,      0,32'h0,        0, 32'h4,        32'h60, 1,0);
    tbl[17] = mk(1,0,16'h0,   0,26'h0,      1,32'h3,        0, 32'h4,        32'h60, 0,0);
    tbl[18] = mk(0,1,16'h8000,1,26'h0,      1,32'h0,        0, 32'h0,        32'h60, 1,0);

    // Reset state
    #2;
    check_all("reset", 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].br, tbl[i].off, tbl[i].jmp, tbl[i].idx, tbl[i].jrr,
           tbl[i].tgt, tbl[i].exc);
      check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_epc, tbl[i].e_fl, tbl[i].e_ae);
    end

    // Asynchronous reset mid-run takes effect without a clock edge
    step(0,0,16'h0,0,26'h0,1,32'h40,0);
    check_all("pre_rst", 32'h40, 32'h60, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_all("async_rst", 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step(0,0,16'h0,0,26'h0,0,32'h0,0);
      check_all($sformatf("restart%0d", k), 32'(k * 4), 32'h0, 1'b0, 1'b0);
    end

    // Randomized run against the reference model
    reset = 1'b1;
    #3;
    @(negedge clk);
    reset = 1'b0;
    m_pc = 32'h0; m_epc = 32'h0; m_fl = 1'b0; m_ae = 1'b0;
    for (int n = 0; n < 500; n++) begin
      logic st, br, jmp, jrr, exc;
      logic [15:0] off;
      logic [25:0] idx;
      logic [31:0] tgt;
      exc = ($urandom_range(0, 15) == 0);
      st  = ($urandom_range(0, 4) == 0);
      jrr = ($urandom_range(0, 5) == 0);
      jmp = ($urandom_range(0, 5) == 0);
      br  = ($urandom_range(0, 3) == 0);
      off = 16'($urandom);
      idx = 26'($urandom);
      tgt = $urandom;
      model_step(st, br, off, jmp, idx, jrr, tgt, exc);
      step(st, br, off, jmp, idx, jrr, tgt, exc);
      check_all($sformatf("rand%0d", n), m_pc, m_epc, m_fl, m_ae);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
